uart_word_tx: RTL and testbench

//  Transmit side of the FIR UART link. Buffers 16-bit FIR result words and sends each word as two
//  8N1 UART frames: low byte first, then high byte. Drives TxD to the host and TxD_busy back to the

---
 rtl/fir_uart_pkg.sv | 25 ++
 rtl/uart_word_tx_if.sv | 11 +
 rtl/word_fifo.sv | 51 +++++
 rtl/uart_word_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_word_tx.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_uart_pkg.sv
// Shared definitions for the FIR UART link: TX state encoding, baud divisor and byte order.
package fir_uart_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_e;

  // Low byte of each word goes on the line first.
  localparam bit LOW_FIRST = 1'b1;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between the wrapper controller (master) and the UART word transmitter (slave).
interface uart_word_tx_if;
  import fir_uart_pkg::*;

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/word_fifo.sv
// Synchronous word FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("word_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  // Read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= {(AW + 1){1'b0}};
      r_rptr <= {(AW + 1){1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_INC;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_INC;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers 16-bit result words and sends each as two back-to-back 8N1 frames on TxD.
module uart_word_tx
  import fir_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_word_tx_if.slave        word_if,
  output logic                 TxD,
  output logic                 TxD_busy,
  output logic                 fifo_full,
  output logic                 word_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_INC  = CW'(1'b1);

  if (BAUD_DIV < 2) begin : g_baud_chk
    $error("uart_word_tx: BAUD_DIV = CLK_FREQ/BAUD must be >= 2");
  end

  tx_state_e           r_state, w_state_nxt;
  logic [CW-1:0]       r_baud_cnt, w_baud_nxt;
  logic [2:0]          r_bit_cnt, w_bit_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic [WORD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_byte_sel, w_sel_nxt;
  logic                r_txd, w_txd_nxt;
  logic                r_word_done, w_done_nxt;

  logic                w_push;
  logic                w_pop;
  logic [WORD_W-1:0]   w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_bit_end;
  logic [7:0]          w_first_byte;
  logic [7:0]          w_second_byte;

  // Ready depends on fullness only; a same-cycle pop never opens a slot.
  assign w_push        = word_if.word_valid && !w_fifo_full;
  assign w_bit_end     = (r_baud_cnt == BIT_LAST);
  assign w_first_byte  = LOW_FIRST ? w_fifo_dout[7:0] : w_fifo_dout[15:8];
  assign w_second_byte = LOW_FIRST ? r_hold[15:8] : r_hold[7:0];

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (word_if.word_in),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_hold_nxt  = r_hold;
    w_sel_nxt   = r_byte_sel;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = {CW{1'b0}};
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_hold_nxt  = w_fifo_dout;
          w_sel_nxt   = 1'b0;
          w_shift_nxt = w_first_byte;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end else begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_baud_nxt = w_bit_end ? {CW{1'b0}} : r_baud_cnt + CNT_INC;
        if (w_bit_end) begin
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_txd_nxt   = 1'b0;
        end
      end
      DATA: begin
        w_baud_nxt = w_bit_end ? {CW{1'b0}} : r_baud_cnt + CNT_INC;
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        w_baud_nxt = w_bit_end ? {CW{1'b0}} : r_baud_cnt + CNT_INC;
        if (w_bit_end) begin
          // Second byte of a word starts straight from the stop bit, no idle gap.
          if (!r_byte_sel) begin
            w_sel_nxt   = 1'b1;
            w_shift_nxt = w_second_byte;
            w_txd_nxt   = 1'b0;
            w_state_nxt = START;
          end else begin
            w_done_nxt  = 1'b1;
            w_txd_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_baud_nxt  = {CW{1'b0}};
        w_txd_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_baud_cnt  <= {CW{1'b0}};
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_hold      <= {WORD_W{1'b0}};
      r_byte_sel  <= 1'b0;
      r_txd       <= 1'b1;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud_cnt  <= w_baud_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_byte_sel  <= w_sel_nxt;
      r_txd       <= w_txd_nxt;
      r_word_done <= w_done_nxt;
    end
  end

  assign TxD                = r_txd;
  assign word_done          = r_word_done;
  assign fifo_full          = w_fifo_full;
  assign word_if.word_ready = !w_fifo_full;
  assign TxD_busy           = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed and random bench for uart_word_tx with a reference 8N1 decoder (BAUD_DIV = 16).
module tb_uart_word_tx;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic TxD, TxD_busy, fifo_full, word_done;

  uart_word_tx_if wif ();

  uart_word_tx #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_if   (wif),
    .TxD       (TxD),
    .TxD_busy  (TxD_busy),
    .fifo_full (fifo_full),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         rx_base  = 0;
  int         exp_base = 0;

  int         done_cnt  = 0;
  int         frame_err = 0;
  logic       dec_active = 1'b0;
  logic       dec_prev   = 1'b1;
  int         dec_cnt    = 0;
  logic [7:0] dec_sh     = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decoder: sample mid-bit relative to each detected falling start edge.
  always @(negedge clk) begin
    if (rst) begin
      dec_active <= 1'b0;
      dec_prev   <= 1'b1;
    end else begin
      dec_prev <= TxD;
      if (!dec_active) begin
        if (dec_prev && !TxD) begin
          dec_active <= 1'b1;
          dec_cnt    <= 1;
          start_q.push_back(cyc);
        end
      end else begin
        dec_cnt <= dec_cnt + 1;
        if (dec_cnt == BD / 2) begin
          if (TxD !== 1'b0) frame_err <= frame_err + 1;
        end else if (dec_cnt == BD / 2 + 9 * BD) begin
          if (TxD !== 1'b1) frame_err <= frame_err + 1;
          rx_q.push_back(dec_sh);
          dec_active <= 1'b0;
        end else if (dec_cnt > BD / 2 && ((dec_cnt - BD / 2) % BD) == 0) begin
          dec_sh <= {TxD, dec_sh[7:1]};
        end
      end
      if (word_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [15:0] w, input int k);
    int         b  = k / BD;
    int         p  = b % 10;
    logic [7:0] by = (b < 10) ? w[7:0] : w[15:8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  task automatic send_word(input logic [15:0] d);
    int   n   = 0;
    logic acc = 1'b0;
    wif.word_in    = d;
    wif.word_valid = 1'b1;
    while (!acc && n < 2000) begin
      acc = wif.word_ready;
      @(negedge clk);
      n++;
    end
    check_eq("send_accept", {31'd0, acc}, 32'd1);
    if (acc) begin
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
    end
  endtask

  task automatic idle_in();
    wif.word_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, (done_cnt >= target)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bytes(input string tag);
    int n_rx = rx_q.size() - rx_base;
    int n_ex = exp_q.size() - exp_base;
    int bad  = 0;
    check_eq({tag, "_count"}, n_rx, n_ex);
    for (int i = 0; i < n_ex && i < n_rx; i++)
      if (rx_q[rx_base+i] !== exp_q[exp_base+i]) bad++;
    check_eq({tag, "_bytes"}, bad, 0);
    rx_base  = rx_q.size();
    exp_base = exp_q.size();
  endtask

  initial begin
    int d0, si, bad, low, seen, n;

    rst            = 1'b1;
    wif.word_valid = 1'b0;
    wif.word_in    = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_txd",   {31'd0, TxD},            32'd1);
    check_eq("rst_busy",  {31'd0, TxD_busy},       32'd0);
    check_eq("rst_done",  {31'd0, word_done},      32'd0);
    check_eq("rst_ready", {31'd0, wif.word_ready}, 32'd1);
    check_eq("rst_full",  {31'd0, fifo_full},      32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single word, cycle-exact waveform
    send_word(16'hA55A);
    idle_in();
    check_eq("t1_txd_before", {31'd0, TxD},      32'd1);
    check_eq("t1_busy_acc",   {31'd0, TxD_busy}, 32'd1);
    @(negedge clk);
    check_eq("t1_start_low",  {31'd0, TxD},      32'd0);
    bad = 0;
    for (int k = 0; k < 20 * BD; k++) begin
      if (TxD !== exp_bit(16'hA55A, k) || word_done !== 1'b0) bad++;
      @(negedge clk);
    end
    check_eq("t1_wave",      bad, 0);
    check_eq("t1_done_320",  {31'd0, word_done}, 32'd1);
    check_eq("t1_busy_fall", {31'd0, TxD_busy},  32'd0);
    @(negedge clk);
    check_eq("t1_done_once", {31'd0, word_done}, 32'd0);
    check_bytes("t1");

    // 2: back-to-back words, gap timing from start edges
    si = start_q.size();
    d0 = done_cnt;
    send_word(16'h1234);
    send_word(16'hBEEF);
    idle_in();
    wait_done("t2_done", d0 + 2, 1500);
    check_eq("t2_starts", start_q.size() - si, 4);
    if (start_q.size() - si >= 4) begin
      check_eq("t2_gap_byte1", start_q[si+1] - start_q[si],   10 * BD);
      check_eq("t2_gap_word",  start_q[si+2] - start_q[si+1], 10 * BD + 1);
      check_eq("t2_gap_byte2", start_q[si+3] - start_q[si+2], 10 * BD);
    end
    check_bytes("t2");

    // 3: overfill the FIFO with valid held high
    d0 = done_cnt;
    send_word(16'h0101);
    send_word(16'h2202);
    send_word(16'h3303);
    send_word(16'h4404);
    send_word(16'h5505);
    check_eq("t3_full",     {31'd0, fifo_full},      32'd1);
    check_eq("t3_not_rdy",  {31'd0, wif.word_ready}, 32'd0);
    send_word(16'h6606);
    idle_in();
    check_eq("t3_acc_after_pop", done_cnt - d0, 1);
    wait_done("t3_done", d0 + 6, 2500);
    check_bytes("t3");

    // 4: reset during DATA bit 3 of the high byte, with another word queued
    d0 = done_cnt;
    send_word(16'hC3C3);
    send_word(16'h7777);
    idle_in();
    n = 0;
    while (TxD !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (14 * BD + 6) @(negedge clk);
    check_eq("t4_txd_bit3", {31'd0, TxD}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t4_rst_txd",  {31'd0, TxD},       32'd1);
    check_eq("t4_rst_busy", {31'd0, TxD_busy},  32'd0);
    check_eq("t4_rst_done", {31'd0, word_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t4_no_done",  done_cnt - d0,           0);
    check_eq("t4_idle_busy", {31'd0, TxD_busy},      32'd0);
    check_eq("t4_idle_txd",  {31'd0, TxD},           32'd1);
    check_eq("t4_ready",     {31'd0, wif.word_ready}, 32'd1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    check_bytes("t4_partial");
    d0 = done_cnt;
    send_word(16'h00FF);
    idle_in();
    wait_done("t4_done", d0 + 1, 800);
    check_bytes("t4_clean");

    // 5: busy envelope across two queued words
    check_eq("t5_busy_pre", {31'd0, TxD_busy}, 32'd0);
    send_word(16'hA1B2);
    send_word(16'hC3D4);
    idle_in();
    check_eq("t5_busy_acc", {31'd0, TxD_busy}, 32'd1);
    low  = 0;
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 1500) begin
      @(negedge clk);
      n++;
      if (word_done) begin
        seen++;
        if (seen == 1) check_eq("t5_busy_between", {31'd0, TxD_busy}, 32'd1);
        else           check_eq("t5_busy_last",    {31'd0, TxD_busy}, 32'd0);
      end else if (!TxD_busy) begin
        low++;
      end
    end
    check_eq("t5_seen", seen, 2);
    check_eq("t5_no_drop", low, 0);
    repeat (2) @(negedge clk);
    check_bytes("t5");

    // 6: random words with random valid gaps
    d0 = done_cnt;
    for (int i = 0; i < 200; i++) begin
      int gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idle_in();
        repeat (gap) @(negedge clk);
      end
      send_word(16'($urandom));
    end
    idle_in();
    wait_done("t6_done", d0 + 200, 4000);
    check_bytes("t6");
    check_eq("frame_err", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
